// File: rtl/addr_latch_8.sv
// ---------------------------------------------------------------------------
// addr_latch_8 -- clocked addressable latch (74x259 style, fully synchronous)
//
// A single data bit (din) is steered by a select address (sl) into one bit of
// a registered output bank. The mode is decoded each rising edge from
// {clr_n, en_n}:
//   11 memory  : q holds
//   10 latch   : q[sl] <= din, other bits hold
//   01 clear   : q <= 0
//   00 demux   : q <= 0 except q[sl] <= din
// An out-of-range select (sl >= WIDTH) writes no bit, so latch holds and
// demux yields an all-zero bank.
//
// Parameters:
//   WIDTH  number of output bits (2 <= WIDTH <= 2**AW)
//   AW     width of the select address
//
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset (q = 0, chg = 0)
//   en_n   active-low enable
//   clr_n  active-low clear / mode select, sampled synchronously
//   sl     select address of the target bit
//   din    data bit to steer
//   q      registered output bank
//   chg    registered pulse, high in the cycle q shows a changed value
//
// Optional feature (macro ADDR_LATCH_READBACK_EN):
//   rd_sl  readback select address
//   rd_q   combinational q[rd_sl], 0 when rd_sl >= WIDTH
// ---------------------------------------------------------------------------
module addr_latch_8 #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en_n,
  input  logic             clr_n,
  input  logic [AW-1:0]    sl,
  input  logic             din,
  output logic [WIDTH-1:0] q,
  output logic             chg
`ifdef ADDR_LATCH_READBACK_EN
  ,
  input  logic [AW-1:0]    rd_sl,
  output logic             rd_q
`endif
);

  typedef enum logic [1:0] {
    MODE_DEMUX  = 2'b00,
    MODE_CLEAR  = 2'b01,
    MODE_LATCH  = 2'b10,
    MODE_MEMORY = 2'b11
  } mode_e;

  mode_e            mode_s;
  logic [WIDTH-1:0] sel_s;
  logic [WIDTH-1:0] wdata_s;
  logic [WIDTH-1:0] q_next_s;
  logic             chg_next_s;
  logic [WIDTH-1:0] q_r;
  logic             chg_r;

  assign mode_s = mode_e'({clr_n, en_n});

  // One-hot decode of the select address; an out-of-range address selects
  // nothing, which gives the hold / all-zero behaviour for free.
  always_comb begin
    sel_s = {WIDTH{1'b0}};
    for (int i = 0; i < WIDTH; i++) begin
      sel_s[i] = ({1'b0, sl} == (AW+1)'(i));
    end
  end

  assign wdata_s = sel_s & {WIDTH{din}};

  // Next-state bank for the decoded mode, and the change flag against it.
  always_comb begin
    q_next_s = q_r;
    case (mode_s)
      MODE_MEMORY: q_next_s = q_r;
      MODE_LATCH:  q_next_s = (q_r & ~sel_s) | wdata_s;
      MODE_CLEAR:  q_next_s = {WIDTH{1'b0}};
      MODE_DEMUX:  q_next_s = wdata_s;
      default:     q_next_s = q_r;
    endcase
    chg_next_s = (q_next_s != q_r);
  end

  // Output bank and change pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r   <= {WIDTH{1'b0}};
      chg_r <= 1'b0;
    end else begin
      q_r   <= q_next_s;
      chg_r <= chg_next_s;
    end
  end

  assign q   = q_r;
  assign chg = chg_r;

`ifdef ADDR_LATCH_READBACK_EN
  logic rd_q_s;

  // Readback mux of the registered bank; out-of-range address reads 0.
  always_comb begin
    rd_q_s = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      rd_q_s = rd_q_s | (q_r[i] & ({1'b0, rd_sl} == (AW+1)'(i)));
    end
  end

  assign rd_q = rd_q_s;
`endif

endmodule
